// File: rtl/nb_pipe_pkg.sv
// nb_pipe_pkg: shared defaults and helpers for the non-blocking stage pipeline
package nb_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;
  localparam int MAX_DEPTH = 256;
  function automatic logic [31:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int k = 0; k < MAX_DEPTH; k++) n += 32'(v[k]);
    return n;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/nb_pipe_stage.sv
// nb_pipe_stage: one data/valid register slot; bubbles clear valid without touching data
module nb_pipe_stage
  import nb_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rdy_i,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             valid_nxt
);
  assign valid_nxt = flush ? 1'b0 : rdy_i ? prev_valid : valid;
  // valid follows its next-state; data only captures real words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= valid_nxt;
      if (rdy_i && prev_valid && !flush) data <= prev_data;
    end
  end
endmodule

// File: rtl/nb_stage_pipeline.sv
// nb_stage_pipeline: valid/ready register chain with bubble collapsing, flush, occupancy and tap
module nb_stage_pipeline
  import nb_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAP_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [cnt_w(DEPTH)-1:0]   count,
  input  logic [TAP_W-1:0]          tap_sel,
  output logic                      tap_valid,
  output logic [WIDTH-1:0]          tap_data
);
  localparam int CW = cnt_w(DEPTH);
  if (WIDTH < 1 || DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_param
    $error("nb_stage_pipeline: WIDTH and DEPTH must be >= 1 and DEPTH <= MAX_DEPTH");
  end
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_nxt;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             tap_hit;
  // a stage can take a word if it is empty or its successor is moving
  always_comb begin
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) rdy[k] = ~valid_q[k] | rdy[k+1];
  end
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    if (i == 0) begin : g_head
      assign pv = in_valid;
      assign pd = in_data;
    end else begin : g_body
      assign pv = valid_q[i-1];
      assign pd = data_q[i-1];
    end
    nb_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .rdy_i      (rdy[i]),
      .prev_valid (pv),
      .prev_data  (pd),
      .valid      (valid_q[i]),
      .data       (data_q[i]),
      .valid_nxt  (valid_nxt[i])
    );
  end
  // occupancy tracks the valid bits being written this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else count <= CW'(popcount(MAX_DEPTH'(valid_nxt)));
  end
  assign tap_hit   = 32'(tap_sel) < DEPTH;
  assign tap_valid = tap_hit & valid_q[tap_sel];
  assign tap_data  = tap_hit ? data_q[tap_sel] : '0;
endmodule

// File: tb/tb_nb_stage_pipeline.sv
// tb_nb_stage_pipeline: vector table plus scoreboard for the stage pipeline
module tb_nb_stage_pipeline;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready, flush, tap_valid;
  logic [7:0] in_data, out_data, tap_data;
  logic [1:0] count, tap_sel;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_cnt;
  } vec_t;
  vec_t tbl [14];

  nb_stage_pipeline #(.WIDTH(8), .DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count),
    .tap_sel   (tap_sel),
    .tap_valid (tap_valid),
    .tap_data  (tap_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  // scoreboard: queue words on acceptance, compare on delivery, drop on flush/reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", out_data, 32'hffff_ffff);
        else chk("sb_out", out_data, sb.pop_front());
      end
      if (flush) sb.delete();
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    tbl = '{
      '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1},
      '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2},
      '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 2'd3},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 2'd0},
      '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h33, 2'd1},
      '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h33, 2'd2},
      '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd3},
      '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3},
      '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd3},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd2},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 2'd1},
      '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA4, 2'd0}
    };
    rst_n = 1'b0;
    tap_sel = 2'd0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_tap_valid", tap_valid, 0);
    chk("rst_tap_data", tap_data, 0);
    chk("rst_in_ready", in_ready, 1);
    #10 rst_n = 1'b1;
    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].iv, tbl[r].id, tbl[r].ordy, 1'b0);
      #1;
      chk($sformatf("r%0d_in_ready", r), in_ready, tbl[r].exp_ir);
      step();
      chk($sformatf("r%0d_out_valid", r), out_valid, tbl[r].exp_ov);
      chk($sformatf("r%0d_out_data", r), out_data, tbl[r].exp_od);
      chk($sformatf("r%0d_count", r), count, tbl[r].exp_cnt);
    end
    drive(1'b1, 8'h01, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0); step();
    drive(1'b1, 8'h02, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0); step();
    chk("bub_count", count, 2);
    chk("bub_out_data", out_data, 8'h01);
    tap_sel = 2'd1; #1;
    chk("bub_tap1_valid", tap_valid, 1);
    chk("bub_tap1_data", tap_data, 8'h02);
    tap_sel = 2'd0; #1;
    chk("bub_tap0_valid", tap_valid, 0);
    step();
    chk("bub_hold_count", count, 2);
    out_ready = 1'b1; step(); step();
    chk("bub_drain_count", count, 0);
    drive(1'b1, 8'h5C, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    tap_sel = 2'd1; #1;
    chk("tap1_valid", tap_valid, 1);
    chk("tap1_data", tap_data, 8'h5C);
    tap_sel = 2'd3; #1;
    chk("tap3_valid", tap_valid, 0);
    chk("tap3_data", tap_data, 0);
    tap_sel = 2'd0; #1;
    chk("tap0_valid", tap_valid, 0);
    chk("tap0_data", tap_data, 8'h5C);
    step(); step();
    chk("tap_drain_count", count, 0);
    drive(1'b1, 8'hB1, 1'b0, 1'b0); step();
    drive(1'b1, 8'hB2, 1'b0, 1'b0); step();
    drive(1'b1, 8'hB3, 1'b0, 1'b0); step();
    chk("fl_full_count", count, 3);
    drive(1'b1, 8'hEE, 1'b0, 1'b1); #1;
    chk("fl_in_ready", in_ready, 0);
    step();
    chk("fl_count", count, 0);
    chk("fl_out_valid", out_valid, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("fl_tap0_valid", tap_valid, 0);
    chk("fl_tap0_data", tap_data, 8'hB3);
    chk("fl_in_ready_after", in_ready, 1);
    step();
    chk("fl_idle_count", count, 0);
    drive(1'b1, 8'hD1, 1'b0, 1'b0); step();
    drive(1'b1, 8'hD2, 1'b0, 1'b0); step();
    drive(1'b1, 8'hD3, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b1); step();
    chk("flpop_count", count, 0);
    drive(1'b1, 8'hC1, 1'b0, 1'b0); step();
    drive(1'b1, 8'hC2, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0); step();
    chk("mrst_pre_out_valid", out_valid, 1);
    chk("mrst_pre_count", count, 2);
    tap_sel = 2'd2; #1;
    rst_n = 1'b0; #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_count", count, 0);
    chk("mrst_tap_data", tap_data, 0);
    chk("mrst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    drive(1'b1, 8'hE5, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step();
    chk("post_rst_out_data", out_data, 8'hE5);
    step();
    chk("post_rst_count", count, 0);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nb_stage_pipeline.md
Name: nb_stage_pipeline

Overview:
- Parametrised chain of non-blocking register stages, generalising the fixed `b <= a; c <= b; d <= c` transfer to WIDTH bits and DEPTH stages.
- Adds per-stage valid tracking, valid/ready backpressure with bubble collapsing, synchronous flush, occupancy count and a debug tap.
- Used as a generic retiming/delay element between producer and consumer blocks on one clock domain.

Parameters:
- WIDTH, 8, data width in bits; must be >= 1.
- DEPTH, 3, number of register stages; must be >= 1. Elaboration error if violated.
- TAP_W, $clog2(DEPTH) (minimum 1), width of tap_sel.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer presents in_data.
- in_data  in  WIDTH  producer data.
- in_ready  out  1  stage 0 can accept this cycle.
- out_valid  out  1  last stage holds valid data.
- out_data  out  WIDTH  last-stage data.
- out_ready  in  1  consumer accepts out_data this cycle.
- flush  in  1  synchronous pipeline clear.
- count  out  $clog2(DEPTH+1)  number of valid stages.
- tap_sel  in  TAP_W  stage index to observe.
- tap_valid  out  1  valid bit of the selected stage.
- tap_data  out  WIDTH  data of the selected stage.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. While rst_n=0, all stage data and valid bits are 0. Outputs: out_valid=0, out_data=0, count=0, tap_valid=0, tap_data=0, in_ready=1 (combinational: empty and flush=0).
- Reset mid-operation: all in-flight data is discarded immediately.
- Stage state: data[i], valid[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives out_valid/out_data directly (registered, no combinational path from in_data).
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = ~valid[i] | rdy[i+1].
  - in_ready = rdy[0] & ~flush.
- Per clock edge, every stage updates with non-blocking semantics, all from pre-edge values:
  - Stage i>0 loads data[i-1] and valid[i-1] when rdy[i]=1.
  - Stage 0 loads in_data and in_valid when rdy[0]=1.
  - A stage with rdy[i]=0 holds its contents.
- Data regs load only when the incoming valid=1. Bubbles do not overwrite data; they clear valid only.
- Bubble collapsing: a stalled tail lets upstream stages fill empty slots. No valid word is ever overwritten or duplicated.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Latency: with the pipe empty and out_ready held at 1, a word accepted at edge N is visible on out_valid after edge N+DEPTH-1 and is consumed at edge N+DEPTH.
- Throughput: 1 word/cycle when out_ready=1.
- Full (all valid=1, out_ready=0): in_ready=0, contents frozen.
- Full with out_ready=1: the chain shifts and in_ready=1 in the same cycle (simultaneous push and pop).
- flush=1 at an edge:
  - All valid bits clear. Data regs are unchanged.
  - No input is accepted (in_ready=0 that cycle).
  - out_valid is still presented that cycle; an output transfer that cycle counts as delivered.
- flush has priority over every shift and over reset release ordering beyond rst_n.
- count = popcount(valid), registered alongside the valid bits. Range 0..DEPTH, no wrap.
- Tap:
  - tap_sel < DEPTH: tap_valid = valid[tap_sel], tap_data = data[tap_sel] (combinational mux).
  - tap_sel >= DEPTH: both outputs are 0.
- in_valid must stay asserted until accepted; the block does not drop offered data.

Decomposition:
- Package nb_pipe_pkg holds:
  - localparam defaults (DEF_WIDTH=8, DEF_DEPTH=3).
  - function popcount(logic [] v) for count.
  - function cnt_w(int depth) returning $clog2(depth+1).
- Sub-module nb_pipe_stage: one stage holding data/valid regs with load enable rdy_i and flush. It is instantiated DEPTH times in a generate loop. The top owns the ready chain, count and tap mux.

Test Plan:
- Reset mid-stream: rst_n=0 at an arbitrary cycle with 2 valid stages -> out_valid=0, count=0, tap_data=0 asynchronously, before the next clk edge.
- Stream, WIDTH=8, DEPTH=3: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> 0x11 seen at out_data 2 edges after acceptance; output order 11, 22, 33; count peaks at 3.
- Backpressure fill: out_ready=0, push 0xA1, 0xA2, 0xA3, 0xA4 -> first three accepted, in_ready=0 on the 4th, count=3, out_data=0xA1 held. Then out_ready=1 for 1 cycle -> 0xA4 accepted in the same cycle, count stays 3.
- Bubble collapse: push 0x01, idle, push 0x02, with out_ready=0 for 3 cycles -> valid pattern compacts to stages 2,1 holding 0x01, 0x02; count=2; no data loss.
- Flush: 3 valid words, assert flush for 1 cycle with in_valid=1 -> next cycle count=0, out_valid=0, in_ready was 0 during flush; in_data not captured.
- Tap: tap_sel=1 with stage 1 holding 0x5C -> tap_valid=1, tap_data=0x5C; tap_sel=3 (DEPTH=3) -> tap_valid=0, tap_data=0.
